// File: rtl/reg_access_pkg.sv
// Shared constants for the register-file access sequencer: opcodes, ALU select
// encodings, FSM states and instruction field positions.
package reg_access_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Instruction word: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm
  localparam int FIELD_W   = 8;
  localparam int OPC_LSB   = 24;
  localparam int DST_LSB   = 16;
  localparam int SRC1_LSB  = 8;
  localparam int SRC2_LSB  = 0;
  localparam int REG_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/reg_access_seq_instr_field_decode.sv
// Combinational opcode decode to ALU/immediate controls plus legality.
// Build option ADDR_CHECK_EN: nonzero upper bits in used register fields are illegal.
module instr_field_decode
  import reg_access_pkg::*;
(
  input  logic [31:0] instr_word,
  output logic [2:0]  alu_sel,
  output logic        imm_sel,
  output logic        neg_sel,
  output logic        legal
);

  logic [7:0] opcode;
  logic       opc_legal;
  logic       uses_src;
  logic       unused_bits;

  assign opcode = instr_word[OPC_LSB +: FIELD_W];

  always_comb begin
    alu_sel   = ALU_FWD;
    imm_sel   = 1'b0;
    neg_sel   = 1'b0;
    opc_legal = 1'b1;
    uses_src  = 1'b1;
    case (opcode)
      OP_LOADI: begin
        imm_sel  = 1'b1;
        uses_src = 1'b0;
      end
      OP_MOV: alu_sel = ALU_FWD;
      OP_ADD: alu_sel = ALU_ADD;
      OP_SUB: begin
        alu_sel = ALU_ADD;
        neg_sel = 1'b1;
      end
      OP_AND: alu_sel = ALU_AND;
      OP_OR:  alu_sel = ALU_OR;
      default: begin
        opc_legal = 1'b0;
        uses_src  = 1'b0;
      end
    endcase
  end

`ifdef ADDR_CHECK_EN
  logic dst_hi_bad;
  logic src1_hi_bad;
  logic src2_hi_bad;

  assign dst_hi_bad  = |instr_word[DST_LSB + REG_IDX_W +: FIELD_W - REG_IDX_W];
  assign src1_hi_bad = |instr_word[SRC1_LSB + REG_IDX_W +: FIELD_W - REG_IDX_W];
  assign src2_hi_bad = |instr_word[SRC2_LSB + REG_IDX_W +: FIELD_W - REG_IDX_W];
  // LOADI has no source registers, so its src fields are immediate/don't-care
  assign legal = opc_legal & ~dst_hi_bad & ~(uses_src & (src1_hi_bad | src2_hi_bad));
  assign unused_bits = ^{instr_word[DST_LSB +: REG_IDX_W],
                         instr_word[SRC1_LSB +: REG_IDX_W],
                         instr_word[SRC2_LSB +: REG_IDX_W]};
`else
  assign legal = opc_legal;
  assign unused_bits = ^{instr_word[OPC_LSB-1:0], uses_src};
`endif

endmodule

// File: rtl/reg_access_seq.sv
// Instruction sequencer driving register-file addresses, write enable and ALU muxes.
// Build option ADDR_CHECK_EN is handled inside instr_field_decode.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | instr_ready high, waiting for a handshake
// ST_DECODE | decoded controls visible; illegal pulse for rejected words
// ST_READ   | addresses stable across the register file posedge read
// ST_EXEC   | ALU settles on registered OUT1/OUT2
// ST_WB     | wr_en high, inaddr stable across posedge and negedge
module reg_access_seq
  import reg_access_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  output logic [AW-1:0] out1addr,
  output logic [AW-1:0] out2addr,
  output logic [AW-1:0] inaddr,
  output logic [DW-1:0] imm,
  output logic          imm_sel,
  output logic          neg_sel,
  output logic [2:0]    alu_sel,
  output logic          wr_en,
  output logic          done,
  output logic          illegal,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          instr_ready_q, instr_ready_d;
  logic [AW-1:0] out1addr_q, out1addr_d;
  logic [AW-1:0] out2addr_q, out2addr_d;
  logic [AW-1:0] inaddr_q, inaddr_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          imm_sel_q, imm_sel_d;
  logic          neg_sel_q, neg_sel_d;
  logic [2:0]    alu_sel_q, alu_sel_d;
  logic          wr_en_q, wr_en_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;
  logic          busy_q, busy_d;

  logic [2:0]    dec_alu_sel;
  logic          dec_imm_sel;
  logic          dec_neg_sel;
  logic          dec_legal;
  logic          handshake;

  instr_field_decode u_decode (
    .instr_word (instr),
    .alu_sel    (dec_alu_sel),
    .imm_sel    (dec_imm_sel),
    .neg_sel    (dec_neg_sel),
    .legal      (dec_legal)
  );

  assign handshake = instr_valid & instr_ready_q;

  always_comb begin
    state_d    = state_q;
    out1addr_d = out1addr_q;
    out2addr_d = out2addr_q;
    inaddr_d   = inaddr_q;
    imm_d      = imm_q;
    imm_sel_d  = imm_sel_q;
    neg_sel_d  = neg_sel_q;
    alu_sel_d  = alu_sel_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Decode happens at the handshake edge so DECODE already shows the
        // loaded controls (or the illegal pulse); rejected words leave them held.
        if (handshake) begin
          state_d = ST_DECODE;
          if (dec_legal) begin
            out1addr_d = instr[SRC1_LSB +: AW];
            out2addr_d = instr[SRC2_LSB +: AW];
            inaddr_d   = instr[DST_LSB +: AW];
            imm_d      = instr[SRC2_LSB +: DW];
            imm_sel_d  = dec_imm_sel;
            neg_sel_d  = dec_neg_sel;
            alu_sel_d  = dec_alu_sel;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_DECODE: state_d = illegal_q ? ST_IDLE : ST_READ;
      ST_READ:   state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_WB;
        wr_en_d = 1'b1;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    instr_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      instr_ready_q <= 1'b1;
      out1addr_q    <= '0;
      out2addr_q    <= '0;
      inaddr_q      <= '0;
      imm_q         <= '0;
      imm_sel_q     <= 1'b0;
      neg_sel_q     <= 1'b0;
      alu_sel_q     <= ALU_FWD;
      wr_en_q       <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_ready_q <= instr_ready_d;
      out1addr_q    <= out1addr_d;
      out2addr_q    <= out2addr_d;
      inaddr_q      <= inaddr_d;
      imm_q         <= imm_d;
      imm_sel_q     <= imm_sel_d;
      neg_sel_q     <= neg_sel_d;
      alu_sel_q     <= alu_sel_d;
      wr_en_q       <= wr_en_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      busy_q        <= busy_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign out1addr    = out1addr_q;
  assign out2addr    = out2addr_q;
  assign inaddr      = inaddr_q;
  assign imm         = imm_q;
  assign imm_sel     = imm_sel_q;
  assign neg_sel     = neg_sel_q;
  assign alu_sel     = alu_sel_q;
  assign wr_en       = wr_en_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_reg_access_seq.sv
// Scoreboard bench for reg_access_seq: driver pushes expected retirements,
// a negedge monitor checks timing and decoded controls against them.
module tb_reg_access_seq;

  logic        CLK;
  logic        RESET;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [2:0]  out1addr, out2addr, inaddr;
  logic [7:0]  imm;
  logic        imm_sel, neg_sel;
  logic [2:0]  alu_sel;
  logic        wr_en, done, illegal, busy;

  reg_access_seq #(.DW(8), .AW(3)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .out1addr    (out1addr),
    .out2addr    (out2addr),
    .inaddr      (inaddr),
    .imm         (imm),
    .imm_sel     (imm_sel),
    .neg_sel     (neg_sel),
    .alu_sel     (alu_sel),
    .wr_en       (wr_en),
    .done        (done),
    .illegal     (illegal),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         t;
    bit         legal;
    logic [2:0] a1, a2, ad;
    logic [7:0] imm;
    bit         imm_sel, neg_sel;
    logic [2:0] alu;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         free_at = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_a1 = '0, prev_a2 = '0, prev_ad = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: opcode semantics straight from the instruction-set table.
  function automatic exp_t model(input logic [31:0] w, input int t);
    exp_t e;
    int   op;
    op = int'(w[31:24]);
    e.t = t;
    e.legal = (op <= 5);
`ifdef ADDR_CHECK_EN
    if (w[23:19] != 0) e.legal = 0;
    if (op >= 1 && op <= 5 && (w[15:11] != 0 || w[7:3] != 0)) e.legal = 0;
`endif
    e.imm_sel = (op == 0);
    e.neg_sel = (op == 3);
    e.alu = (op == 2 || op == 3) ? 3'd1 : (op == 4) ? 3'd2 : (op == 5) ? 3'd3 : 3'd0;
    e.imm = w[7:0];
    if (e.legal) begin
      e.a1 = w[10:8];
      e.a2 = w[2:0];
      e.ad = w[18:16];
    end else begin
      e.a1 = prev_a1;
      e.a2 = prev_a2;
      e.ad = prev_ad;
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] w, output int t_hs);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge CLK);
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    t_hs = cyc + 1;
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: instr_ready stayed %0b, required 1", instr_ready);
      t_hs = -1;
    end else begin
      @(posedge CLK);
      e = model(w, t_hs);
      sb.push_back(e);
      free_at = t_hs + (e.legal ? 4 : 1);
      if (e.legal) begin
        prev_a1 = e.a1;
        prev_a2 = e.a2;
        prev_ad = e.ad;
      end
    end
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      r = $urandom();
      instr_valid = 1'b0;
      instr = r;
    end
  endtask

  exp_t h;
  bit   have;
  int   p;

  always @(negedge CLK) begin
    if (!RESET && mon_en) begin
      have = (sb.size() > 0);
      if (have) h = sb[0];
      p = have ? (cyc - h.t) : -1;
      chk("wr_en", wr_en, have && h.legal && p == 3);
      chk("done", done, have && h.legal && p == 4);
      chk("illegal", illegal, have && !h.legal && p == 0);
      chk("instr_ready", instr_ready, cyc >= free_at);
      chk("busy", busy, cyc < free_at);
      if (have && h.legal && p >= 0 && p <= 3) begin
        chk("out1addr", out1addr, h.a1);
        chk("out2addr", out2addr, h.a2);
        chk("inaddr", inaddr, h.ad);
        chk("imm", imm, h.imm);
        chk("imm_sel", imm_sel, h.imm_sel);
        chk("neg_sel", neg_sel, h.neg_sel);
        chk("alu_sel", alu_sel, h.alu);
      end
      if (have && !h.legal && p == 0) begin
        chk("held_out1addr", out1addr, h.a1);
        chk("held_out2addr", out2addr, h.a2);
        chk("held_inaddr", inaddr, h.ad);
      end
      if (have && ((h.legal && p >= 4) || (!h.legal && p >= 0))) void'(sb.pop_front());
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr_ready"}, instr_ready, 1);
    chk({tag, "_zero_outs"},
        {out1addr, out2addr, inaddr, imm, imm_sel, neg_sel, alu_sel, wr_en, done, illegal, busy}, 0);
  endtask

  initial begin
    int          t1, t2, t3;
    int          r;
    logic [31:0] w, rnd;
    logic [7:0]  op;

    RESET = 1'b1;
    instr_valid = 1'b0;
    instr = 32'h0;
    #3;
    check_reset_outputs("reset");
    @(negedge CLK);
    #2 RESET = 1'b0;
    mon_en = 1'b1;

    issue(32'h0003002A, t1);   // LOADI r3 <- 0x2A
    idle(1);
    issue(32'h02050102, t1);   // ADD r5 <- r1 + r2
    idle(1);
    issue(32'h03050102, t1);   // SUB
    idle(1);
    issue(32'h07010101, t1);   // illegal opcode
    idle(1);
    issue(32'h01020009, t1);   // MOV, upper src2 bits set
    idle(1);
    issue(32'h02010101, t1);   // dest == src1 == src2
    issue(32'hFF000000, t1);

    // Back-to-back with instr_valid held: second handshake in the done cycle
    issue(32'h02030405, t1);
    issue(32'h02060700, t2);
    chk("back_to_back_gap", t2 - t1, 5);
    idle(2);

    // Reset during EXEC of an AND aborts without wr_en or done
    issue(32'h04020301, t3);
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    free_at = 0;
    prev_a1 = '0;
    prev_a2 = '0;
    prev_ad = '0;
    @(posedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b0;
    idle(6);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 3);
      if (r > 0) idle(r - 1);
      r = $urandom_range(0, 15);
      op = (r < 12) ? 8'(r % 6) : 8'($urandom_range(6, 255));
      rnd = $urandom();
      if ($urandom_range(0, 3) == 0) rnd = rnd & 32'h00070707;
      w = {op, rnd[23:0]};
      issue(w, t1);
    end
    idle(8);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
